// File: rtl/funnel_pkg.sv
// Shared types and defaults for the funnel arbitration blocks.
package funnel_pkg;

    localparam int unsigned FUNNEL_N_DEFAULT = 4;

    typedef enum logic {
        FUNNEL_ARB_IDLE = 1'b0,
        FUNNEL_ARB_BUSY = 1'b1
    } funnel_arb_state_e;

endpackage

// File: rtl/funnel_rr_pick.sv
// Rotate-priority encoder: first set bit of elig scanning upward from ptr, wrapping modulo N.
module funnel_rr_pick
    import funnel_pkg::*;
#(
    parameter int unsigned N     = FUNNEL_N_DEFAULT,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned w_pos;
        w_pos = 0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            // ptr < N and k < N, so one conditional subtract wraps the sum
            w_pos = 32'(ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!valid && elig[SEL_W'(w_pos)]) begin
                idx   = SEL_W'(w_pos);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/funnel_rr_arb.sv
// Round-robin burst arbiter sharing one funnel input stream between N requesters.
// Optional FUNNEL_RR_ARB_PRIO0_EN: requester 0 gets strict priority, the rest rotate.
module funnel_rr_arb
    import funnel_pkg::*;
#(
    parameter int unsigned N     = FUNNEL_N_DEFAULT,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     t_req,
    input  logic [N-1:0]     t_last,
    output logic [N-1:0]     t_ack,
    input  logic             t_cfg_req,
    input  logic [N-1:0]     t_cfg_mask,
    output logic             t_cfg_ack,
    output logic             i_req,
    output logic             i_last,
    input  logic             i_ack,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    funnel_arb_state_e r_state;
    funnel_arb_state_e w_state_nxt;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic [SEL_W-1:0]  r_rr_ptr;
    logic [SEL_W-1:0]  w_rr_ptr_nxt;
    logic [SEL_W-1:0]  w_rr_inc;
    logic [N-1:0]      r_mask;
    logic [N-1:0]      w_mask_nxt;
    logic              r_busy;

    logic [N-1:0]      w_elig;
    logic [N-1:0]      w_pick_elig;
    logic [SEL_W-1:0]  w_pick_idx;
    logic              w_pick_valid;
    logic [SEL_W-1:0]  w_grant_idx;
    logic              w_grant_vld;
    logic              w_hold_ptr;
    logic              w_burst_end;

    assign w_elig = t_req & r_mask;

`ifdef FUNNEL_RR_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation; the encoder only arbitrates 1..N-1
    assign w_pick_elig = {w_elig[N-1:1], 1'b0};
    assign w_grant_idx = w_elig[0] ? '0 : w_pick_idx;
    assign w_grant_vld = w_elig[0] | w_pick_valid;
    assign w_hold_ptr  = (r_sel == '0);
`else
    assign w_pick_elig = w_elig;
    assign w_grant_idx = w_pick_idx;
    assign w_grant_vld = w_pick_valid;
    assign w_hold_ptr  = 1'b0;
`endif

    funnel_rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .elig  (w_pick_elig),
        .ptr   (r_rr_ptr),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    assign w_rr_inc    = (r_sel == SEL_W'(N - 1)) ? '0 : r_sel + SEL_W'(1);
    assign w_burst_end = (r_state == FUNNEL_ARB_BUSY) & i_ack & t_req[r_sel] & t_last[r_sel];

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_rr_ptr_nxt = r_rr_ptr;
        w_mask_nxt   = r_mask;
        i_req        = 1'b0;
        i_last       = 1'b0;
        t_ack        = '0;
        t_cfg_ack    = 1'b0;
        case (r_state)
            FUNNEL_ARB_IDLE: begin
                t_cfg_ack = 1'b1;
                // A same-cycle config write only affects the next arbitration
                if (t_cfg_req) begin
                    w_mask_nxt = t_cfg_mask;
                end
                if (w_grant_vld) begin
                    w_sel_nxt   = w_grant_idx;
                    w_state_nxt = FUNNEL_ARB_BUSY;
                end
            end
            FUNNEL_ARB_BUSY: begin
                i_req        = t_req[r_sel];
                i_last       = t_last[r_sel];
                t_ack[r_sel] = i_ack & t_req[r_sel];
                if (w_burst_end) begin
                    w_state_nxt = FUNNEL_ARB_IDLE;
                    if (!w_hold_ptr) begin
                        w_rr_ptr_nxt = w_rr_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = FUNNEL_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= FUNNEL_ARB_IDLE;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_mask   <= '1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_mask   <= w_mask_nxt;
            r_busy   <= (w_state_nxt == FUNNEL_ARB_BUSY);
        end
    end

    assign sel  = r_sel;
    assign busy = r_busy;

endmodule

// File: tb/tb_funnel_rr_arb.sv
// Scoreboard bench for funnel_rr_arb: directed requester bursts, expected beats queued up front.
module tb_funnel_rr_arb;

    localparam int unsigned N     = 4;
    localparam int unsigned SEL_W = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N-1:0]     t_req = '0;
    logic [N-1:0]     t_last = '0;
    logic [N-1:0]     t_ack;
    logic             t_cfg_req = 1'b0;
    logic [N-1:0]     t_cfg_mask = '1;
    logic             t_cfg_ack;
    logic             i_req;
    logic             i_last;
    logic             i_ack = 1'b1;
    logic [SEL_W-1:0] sel;
    logic             busy;

    funnel_rr_arb #(.N(N), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .t_req      (t_req),
        .t_last     (t_last),
        .t_ack      (t_ack),
        .t_cfg_req  (t_cfg_req),
        .t_cfg_mask (t_cfg_mask),
        .t_cfg_ack  (t_cfg_ack),
        .i_req      (i_req),
        .i_last     (i_last),
        .i_ack      (i_ack),
        .sel        (sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [N-1:0]     ack;
        logic             last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    int          bursts_left[N];
    int          blen[N];
    int          beat_left[N];
    logic [N-1:0] ack_s = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int s, input bit last);
        beat_t e;
        e.sel  = SEL_W'(s);
        e.ack  = N'(1 << s);
        e.last = last;
        sb.push_back(e);
    endtask

    // Monitor: every beat must match the head of the scoreboard; no ack outside a beat
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (i_req && i_ack) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got sel=%0d ack=%b last=%b expected no beat", sel, t_ack, i_last);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    if ({sel, t_ack, i_last} !== {e.sel, e.ack, e.last}) begin
                        errors++;
                        $display("FAIL beat: got sel=%0d ack=%b last=%b expected sel=%0d ack=%b last=%b",
                                 sel, t_ack, i_last, e.sel, e.ack, e.last);
                    end
                end
            end else if (t_ack !== '0) begin
                errors++;
                $display("FAIL ack_no_beat: got ack=%b expected 0", t_ack);
            end
        end
    end

    task automatic apply_model();
        for (int r = 0; r < N; r++) begin
            if (beat_left[r] == 0 && bursts_left[r] > 0) begin
                beat_left[r] = blen[r];
                bursts_left[r]--;
            end
            t_req[r]  = (beat_left[r] > 0);
            t_last[r] = (beat_left[r] <= 1);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < N; r++) begin
            bursts_left[r] = 0;
            blen[r]        = 0;
            beat_left[r]   = 0;
        end
        apply_model();
    endtask

    task automatic setup(input int r, input int nb, input int len);
        bursts_left[r] = nb;
        blen[r]        = len;
    endtask

    task automatic neg_half();
        @(negedge clk);
        ack_s = t_ack;
    endtask

    task automatic pos_half();
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (ack_s[r] && beat_left[r] > 0) beat_left[r]--;
        end
        ack_s = '0;
        apply_model();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        t_cfg_req = 1'b0;
        i_ack     = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ack_s   = '0;
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            neg_half();
            n++;
            pos_half();
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic tail(input int k);
        repeat (k) begin
            neg_half();
            pos_half();
        end
    endtask

    initial begin
        int n;
        clear_model();
        do_reset();
        mon_en = 1'b1;

        // Reset values
        neg_half();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_i_req", 32'(i_req), 32'd0);
        chk("rst_i_last", 32'(i_last), 32'd0);
        chk("rst_t_ack", 32'(t_ack), 32'd0);
        chk("rst_cfg_ack", 32'(t_cfg_ack), 32'd1);
        chk("rst_sel", 32'(sel), 32'd0);
        pos_half();

        // Requesters 0 and 2, two-beat bursts each
        push(0, 0); push(0, 1); push(2, 0); push(2, 1);
        setup(0, 1, 2); setup(2, 1, 2);
        apply_model();
        drain(40, n);
        chk("t1_cycles", 32'(n), 32'd6);
        tail(4);

        // rr_ptr should now be 3
`ifdef FUNNEL_RR_ARB_PRIO0_EN
        push(0, 1); push(3, 1);
`else
        push(3, 1); push(0, 1);
`endif
        setup(0, 1, 1); setup(3, 1, 1);
        apply_model();
        drain(40, n);
        tail(4);

        // All four requesting one-beat bursts
        do_reset();
`ifdef FUNNEL_RR_ARB_PRIO0_EN
        push(0, 1); push(0, 1); push(0, 1); push(1, 1); push(2, 1); push(3, 1);
        setup(0, 3, 1); setup(1, 1, 1); setup(2, 1, 1); setup(3, 1, 1);
`else
        push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(0, 1); push(1, 1);
        setup(0, 2, 1); setup(1, 2, 1); setup(2, 1, 1); setup(3, 1, 1);
`endif
        apply_model();
        drain(60, n);
        chk("t2_cycles", 32'(n), 32'd12);
        tail(4);

        // i_ack stall mid-burst on sel=1
        do_reset();
        push(1, 0); push(1, 0); push(1, 1); push(2, 1);
        setup(1, 1, 3); setup(2, 1, 1);
        apply_model();
        tail(2);
        i_ack = 1'b0;
        repeat (3) begin
            neg_half();
            chk("stall_i_req", 32'(i_req), 32'd1);
            chk("stall_t_ack", 32'(t_ack), 32'd0);
            chk("stall_sel", 32'(sel), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
            pos_half();
        end
        i_ack = 1'b1;
        drain(40, n);
        tail(4);

        // Config write issued while busy
        do_reset();
`ifdef FUNNEL_RR_ARB_PRIO0_EN
        push(0, 0); push(0, 1); push(0, 0); push(0, 1);
`else
        push(0, 0); push(0, 1);
`endif
        push(1, 0); push(1, 1); push(1, 0); push(1, 1);
        setup(0, 3, 2); setup(1, 2, 2);
        apply_model();
        tail(1);
        t_cfg_req  = 1'b1;
        t_cfg_mask = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            neg_half();
            chk("cfg_ack_busy", 32'(t_cfg_ack), (k == 2) ? 32'd1 : 32'd0);
            pos_half();
        end
        t_cfg_req = 1'b0;
        drain(60, n);
        tail(10);
        neg_half();
        chk("masked_idle", 32'(busy), 32'd0);
        pos_half();

        // Config write and grant in the same IDLE cycle: grant uses old mask
        do_reset();
        push(0, 1);
        setup(0, 2, 1);
        apply_model();
        t_cfg_req  = 1'b1;
        t_cfg_mask = 4'b1110;
        neg_half();
        chk("cfg_ack_idle", 32'(t_cfg_ack), 32'd1);
        pos_half();
        t_cfg_req = 1'b0;
        drain(20, n);
        tail(8);
        neg_half();
        chk("masked_req0", 32'(i_req), 32'd0);
        pos_half();

        // Reset during beat 2 of a 4-beat burst (mask still 1110)
        clear_model();
        push(2, 0); push(2, 0);
        setup(2, 1, 4);
        apply_model();
        tail(2);
        reset_n = 1'b0;
        tail(1);
        reset_n = 1'b1;
        clear_model();
        neg_half();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_i_req", 32'(i_req), 32'd0);
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_cfg_ack", 32'(t_cfg_ack), 32'd1);
        chk("midrst_sb", 32'(sb.size()), 32'd0);
        pos_half();

        // Mask back to all ones and rr_ptr back to 0
        push(0, 1); push(3, 1);
        setup(0, 1, 1); setup(3, 1, 1);
        apply_model();
        drain(40, n);
        tail(4);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
